// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types, limits and helpers for the shared-adder arbiter
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Widest one-hot grant vector the arbiter is built for
   localparam int MAX_REQ = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, one-hot grant plus index, searched from ptr upward with wrap
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   // Scan from the farthest candidate back to ptr so the nearest valid requester is written last and wins
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (en_i && req_i[(int'(ptr_i) + k) % N]) begin
            found_o = 1'b1;
            idx_o   = IW'((int'(ptr_i) + k) % N);
         end
      end
      if (found_o) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin sharing of one external adder among NUM_REQ requesters; optional carry-chain lock via ADDER_ARB_LOCK_EN
module adder_share_arb
   import adder_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ID_W       = clog2(NUM_REQ)
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]            req_ci,
`ifdef ADDER_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            req_lock,
`endif
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   output logic                          add_ci,
   input  logic [DATA_WIDTH-1:0]         add_s,
   input  logic                          add_co,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_sum,
   output logic                          rsp_co
);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || ID_W != clog2(NUM_REQ)) begin : g_bad_cfg
      $error("adder_share_arb: unsupported NUM_REQ/ID_W combination");
   end

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [ID_W-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]    arb_req, gnt;
   logic                  found, accept, rsp_done, lock_act;
   logic [DATA_WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
   logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
   logic                  add_ci_q, add_ci_d;
   logic                  rsp_co_q, rsp_co_d;
   logic                  rsp_valid_q, rsp_valid_d;

`ifdef ADDER_ARB_LOCK_EN
   logic lock_q, lock_d;

   // While locked only the previous owner may be granted; everyone else is masked off
   assign lock_act = lock_q;
   assign arb_req  = lock_q ? (req_valid & (NUM_REQ'(1) << id_q)) : req_valid;

   // Lock follows the req_lock bit of every accepted request
   always_comb begin
      lock_d = lock_q;
      if (accept) lock_d = req_lock[gnt_idx];
   end

   // Lock register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) lock_q <= 1'b0;
      else            lock_q <= lock_d;
   end
`else
   assign lock_act = 1'b0;
   assign arb_req  = req_valid;
`endif

   // Grant only in IDLE and never while reset is asserted
   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_rr_arbiter (
      .req_i   (arb_req),
      .ptr_i   (rr_ptr_q),
      .en_i    ((state_q == IDLE) && sys_rst_n),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .found_o (found)
   );

   // The grant is only ever raised for a valid requester, so a found grant is the handshake
   assign accept   = found;
   assign rsp_done = (state_q == RESP) && rsp_ready;

   // FSM state register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // FSM next state: one accept, one settle cycle, then wait for the consumer
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: grant straight from the arbiter, everything else from registers
   always_comb begin
      req_ready = gnt;
      add_a     = add_a_q;
      add_b     = add_b_q;
      add_ci    = add_ci_q;
      rsp_valid = rsp_valid_q;
      rsp_id    = id_q;
      rsp_sum   = rsp_sum_q;
      rsp_co    = rsp_co_q;
   end

   // Datapath next state: capture operands on accept, sample the adder in EXEC, free the slot on response
   always_comb begin
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_ci_d    = add_ci_q;
      id_d        = id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_co_d    = rsp_co_q;
      rsp_valid_d = rsp_valid_q;
      rr_ptr_d    = rr_ptr_q;
      if (accept) begin
         add_a_d  = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         add_b_d  = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         add_ci_d = lock_act ? rsp_co_q : req_ci[gnt_idx];
         id_d     = gnt_idx;
      end
      if (state_q == EXEC) begin
         rsp_sum_d   = add_s;
         rsp_co_d    = add_co;
         rsp_valid_d = 1'b1;
      end
      if (rsp_done) begin
         rsp_valid_d = 1'b0;
         rr_ptr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end
   end

   // Datapath registers, all cleared by reset
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_ci_q    <= 1'b0;
         id_q        <= '0;
         rsp_sum_q   <= '0;
         rsp_co_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
      end else begin
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_ci_q    <= add_ci_d;
         id_q        <= id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_co_q    <= rsp_co_d;
         rsp_valid_q <= rsp_valid_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed table-driven bench for adder_share_arb with a behavioural 64-bit adder
module tb_adder_share_arb;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid, req_ready, req_ci;
   logic [255:0] req_a, req_b;
`ifdef ADDER_ARB_LOCK_EN
   logic [3:0]   req_lock;
`endif
   logic [63:0]  add_a, add_b, add_s;
   logic         add_ci, add_co;
   logic         rsp_valid, rsp_ready, rsp_co;
   logic [1:0]   rsp_id;
   logic [63:0]  rsp_sum;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          idx;
      logic [63:0] a;
      logic [63:0] b;
      logic        ci;
      logic [63:0] sum;
      logic        co;
   } vec_t;

   vec_t tbl[6];

   assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + 65'(add_ci);

   adder_share_arb #(
      .NUM_REQ    (4),
      .DATA_WIDTH (64),
      .ID_W       (2)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ci    (req_ci),
`ifdef ADDER_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .add_a     (add_a),
      .add_b     (add_b),
      .add_ci    (add_ci),
      .add_s     (add_s),
      .add_co    (add_co),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_co    (rsp_co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish within 500us");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic wait_grant(input string nm, input logic [3:0] exp);
      int k;
      k = 0;
      #1;
      while (req_ready == 4'b0 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(nm, req_ready, exp);
   endtask

   task automatic do_op(input int idx, input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input logic lk, input logic eci, input logic [63:0] es, input logic eco,
                        input logic [3:0] other);
      req_a[idx*64 +: 64] = a;
      req_b[idx*64 +: 64] = b;
      req_ci[idx]         = ci;
`ifdef ADDER_ARB_LOCK_EN
      req_lock[idx]       = lk;
`else
      if (lk) $display("note: lock requested without lock support");
`endif
      rsp_ready = 1'b1;
      req_valid = other | (4'b0001 << idx);
      wait_grant("grant", 4'b0001 << idx);
      @(negedge clk);
      req_valid = other;
      chk("exec_ready", req_ready, 4'b0);
      chk("exec_valid", rsp_valid, 1'b0);
      chk("exec_a", add_a, a);
      chk("exec_b", add_b, b);
      chk("exec_ci", add_ci, eci);
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_sum", rsp_sum, es);
      chk("rsp_co", rsp_co, eco);
      chk("rsp_id", rsp_id, 128'(idx));
      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{0, 64'd5, 64'd7, 1'b1, 64'd13, 1'b0};
      tbl[1] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
      tbl[2] = '{1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd1, 1'b1};
      tbl[3] = '{3, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0};
      tbl[4] = '{1, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
      tbl[5] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

      rst_n     = 1'b0;
      req_valid = 4'b0001;
      req_a     = '0;
      req_b     = '0;
      req_ci    = '0;
`ifdef ADDER_ARB_LOCK_EN
      req_lock  = '0;
`endif
      rsp_ready = 1'b0;

      // reset state, with a requester already valid
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 4'b0);
      chk("rst_state", {rsp_valid, rsp_id, rsp_co, add_ci}, 5'b0);
      chk("rst_data", {rsp_sum, add_a}, 128'b0);
      chk("rst_add_b", add_b, 64'b0);
      req_valid = 4'b0;
      rst_n     = 1'b1;

      // table of single-requester operations
      for (int i = 0; i < 6; i++)
         do_op(tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, tbl[i].ci, tbl[i].sum, tbl[i].co, 4'b0);

      // back-pressure: response held stable and no grants while rsp_ready is low
      req_a[64 +: 64] = 64'd100;
      req_b[64 +: 64] = 64'd23;
      req_ci[1]       = 1'b0;
      req_a[192 +: 64] = 64'd7;
      req_b[192 +: 64] = 64'd8;
      req_ci[3]        = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      wait_grant("bp_grant", 4'b0010);
      @(negedge clk);
      req_valid = 4'b1000;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold", {rsp_valid, rsp_sum, rsp_id, req_ready}, {1'b1, 64'd123, 2'd1, 4'b0});
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", rsp_valid, 1'b0);
      chk("bp_next_grant", req_ready, 4'b1000);

      // reset while req3 is in EXEC
      @(negedge clk);
      req_valid = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", req_ready, 4'b0);
      chk("mid_rst_valid", rsp_valid, 1'b0);
      chk("mid_rst_add_a", add_a, 64'b0);
      @(negedge clk);
      chk("mid_rst_hold", {req_ready, rsp_valid}, 5'b0);
      for (int i = 0; i < 4; i++) begin
         req_a[i*64 +: 64] = 64'(i * 10);
         req_b[i*64 +: 64] = 64'(i);
         req_ci[i]         = 1'b0;
      end
      rst_n = 1'b1;
      #1;
      chk("post_rst_grant", req_ready, 4'b0001);
      chk("post_rst_valid", rsp_valid, 1'b0);

      // all four valid: grants rotate 0,1,2,3,0
      for (int n = 0; n < 5; n++) begin
         wait_grant("rr_grant", 4'b0001 << (n % 4));
         @(negedge clk);
         @(negedge clk);
         chk("rr_id", rsp_id, 128'(n % 4));
         chk("rr_sum", rsp_sum, 128'(11 * (n % 4)));
         @(negedge clk);
      end
      req_valid = 4'b0;

`ifdef ADDER_ARB_LOCK_EN
      // two-word carry chain on req1 with req3 competing
      do_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 4'b0);
      req_a[192 +: 64] = 64'd5;
      req_b[192 +: 64] = 64'd5;
      req_lock[3]      = 1'b0;
      req_valid        = 4'b1000;
      #1;
      chk("lock_holdoff", req_ready, 4'b0);
      @(negedge clk);
      #1;
      chk("lock_holdoff2", req_ready, 4'b0);
      do_op(1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0, 4'b1000);
      #1;
      chk("lock_release", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = 4'b0;
      repeat (3) @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
